// File: rtl/div_unit.sv
// Multi-cycle restoring divider for DIV/DIVU in the execute stage.
// Produces {remainder, quotient} after WIDTH shift-subtract steps; ready low stalls E.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_div,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 annul,
  input  logic                 stall,
  output logic                 ready,
  output logic [2*WIDTH-1:0]   result,
  output logic [1:0]           state_dbg
);

  // Handshake: ready=0 means the instruction in E must be held; a held start
  // only launches a new divide from IDLE, so a stalled DONE never recomputes.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvsr_q;
  logic             sign_q;
  logic             sign_r;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             no_borrow;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] dvd_next;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  always_comb begin
    a_mag     = (signed_div && a[WIDTH-1]) ? -a : a;
    b_mag     = (signed_div && b[WIDTH-1]) ? -b : b;
    // Dividend register doubles as the quotient: its MSB feeds the remainder
    // and each quotient bit shifts in at the bottom.
    shifted   = {rem_q, dvd_q[WIDTH-1]};
    diff      = shifted - {1'b0, dvsr_q};
    no_borrow = ~diff[WIDTH];
    rem_next  = no_borrow ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    dvd_next  = {dvd_q[WIDTH-2:0], no_borrow};
    q_fix     = sign_q ? -dvd_next : dvd_next;
    r_fix     = sign_r ? -rem_next : rem_next;
  end

  assign ready     = (state == DONE) || ((state == IDLE) && !start);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      result <= '0;
      dvd_q  <= '0;
      rem_q  <= '0;
      dvsr_q <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
    end else if (annul) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            dvd_q  <= a_mag;
            dvsr_q <= b_mag;
            rem_q  <= '0;
            sign_q <= signed_div & (a[WIDTH-1] ^ b[WIDTH-1]);
            sign_r <= signed_div & a[WIDTH-1];
            count  <= '0;
            state  <= BUSY;
          end
        end
        BUSY: begin
          dvd_q <= dvd_next;
          rem_q <= rem_next;
          count <= count + 1'b1;
          if (count == LAST) begin
            result <= {r_fix, q_fix};
            state  <= DONE;
          end
        end
        DONE: begin
          if (!stall) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle 32-bit integer divider for DIV/DIVU, living in the execute stage next to the ALU.
- Drives the ready signal the hazard unit consumes as alu_ready_E; the hazard unit turns a low ready into alu_stall_E and freezes F/D/E/M/W.
- Consumes the hazard unit's longest_stall so that a result held across an unrelated stall is not recomputed.
- Produces {HI=remainder, LO=quotient} for the HI/LO write path.

Parameters:
- WIDTH, 32, operand width; iteration count equals WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  a DIV/DIVU instruction is in E (held high while it stays in E).
- signed_div  in  1  1 = DIV (signed), 0 = DIVU; sampled with start.
- a  in  WIDTH  dividend (rs_E forwarded value); sampled with start.
- b  in  WIDTH  divisor (rt_E forwarded value); sampled with start.
- annul  in  1  Flush_E / exception flush; aborts any operation.
- stall  in  1  longest_stall from the hazard unit.
- ready  out  1  0 = E must stall for the divider; to alu_ready_E.
- result  out  2*WIDTH  {remainder, quotient}.

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset: state = IDLE, counter = 0, result = 0, ready = 1.
- IDLE:
  - If start & ~annul: latch |a| and |b| (two's-complement magnitude when signed_div, raw otherwise), latch sign_q = a[MSB]^b[MSB] and sign_r = a[MSB] (both forced 0 when unsigned), then go to BUSY with counter = 0.
  - Else remain in IDLE.
- BUSY:
  - One restoring shift-subtract step per cycle: partial remainder shifted left by 1 with the next dividend bit; subtract divisor if no borrow; quotient bit = no-borrow.
  - counter increments each cycle; after WIDTH steps (counter == WIDTH-1 step done) go to DONE and register the sign-corrected result.
- DONE:
  - result held stable.
  - Go to IDLE when ~stall (the instruction leaves E this edge); otherwise stay in DONE.
- ready is combinational:
  - 1 in DONE.
  - 1 in IDLE when ~start.
  - 0 in IDLE when start.
  - 0 in BUSY.
  - ready never depends combinationally on stall, so there is no loop through the hazard unit.
- Latency: start seen in IDLE at cycle T; BUSY on T+1..T+WIDTH; DONE (ready=1, result valid) at T+WIDTH+1 = T+33 for WIDTH=32.
- Sign fix: quotient negated if sign_q; remainder negated if sign_r. Remainder sign always follows dividend (MIPS truncation).
- Divide by zero: no trap. Quotient = all ones before sign fix, remainder = |a|, both then sign-corrected. Unsigned: q = 0xFFFFFFFF, r = a.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF gives q = 0x80000000, r = 0; no trap.
- annul:
  - In any state, the next state is IDLE and the counter is cleared.
  - result keeps its last value.
  - annul has priority over start and over stall.
- rst mid-operation: same as the reset values above, from any state.
- Back-to-back divides: after DONE→IDLE, a new start in the following cycle begins a fresh operation. A start held across DONE while stall=1 does not restart.

Test Plan:
- DIVU a=100, b=7, stall=0 → ready=0 for 33 cycles, then ready=1 at T+33 with result={0x00000002,0x0000000E}; IDLE next cycle.
- DIV a=-7 (0xFFFFFFF9), b=2 → result={0xFFFFFFFF,0xFFFFFFFD} (r=-1, q=-3); DIV a=0x80000000, b=0xFFFFFFFF → {0x00000000,0x80000000}.
- DIVU a=0x12345678, b=0 → {0x12345678,0xFFFFFFFF}; DIV a=-5, b=0 → {0xFFFFFFFB,0x00000001}.
- Reach DONE with stall=1 held 5 cycles and start held → ready stays 1 and result is unchanged throughout; no second computation; IDLE the cycle after stall drops.
- Assert annul at cycle 10 of BUSY → IDLE next cycle, ready=1 once start drops. A new DIVU 9/3 then completes in 33 cycles with {0,3}.
- Assert rst at cycle 20 of BUSY → IDLE with result=0 and ready=1 the next cycle; a subsequent divide completes normally.
